// File: rtl/wavelet_channel_scanner_if.sv
// Bus between the wavelet filter bank's output mux, firmware-facing status, and the channel scanner.
// The master side drives the sweep request, mux sample, threshold and read index; the scanner is the slave.
interface wavelet_channel_scanner_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_BITS    = 8,
  parameter int CH_BITS      = 3
);
  logic                    sweep_start;
  logic [DATA_BITS-1:0]    wavelet_value;
  logic [DATA_BITS-1:0]    threshold;
  logic [CH_BITS-1:0]      read_channel;
  logic [7:0]              select_output_channel;
  logic [DATA_BITS-1:0]    peak;
  logic [NUM_CHANNELS-1:0] active;
  logic                    busy;
  logic                    sweep_done;
  logic                    overrun;

  modport master (
    output sweep_start, wavelet_value, threshold, read_channel,
    input  select_output_channel, peak, active, busy, sweep_done, overrun
  );

  modport slave (
    input  sweep_start, wavelet_value, threshold, read_channel,
    output select_output_channel, peak, active, busy, sweep_done, overrun
  );
endinterface

// File: rtl/wavelet_channel_scanner.sv
// Sweeps the wavelet output mux channel by channel, keeping a decaying peak-hold of |sample|
// and a threshold-activity bit per channel.
module wavelet_channel_scanner #(
  parameter int NUM_CHANNELS  = 8,
  parameter int DATA_BITS     = 8,
  parameter int CH_BITS       = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int DECAY_SHIFT   = 4
) (
  input logic                   clk,
  input logic                   rst,
  wavelet_channel_scanner_if.slave bus
);

  localparam int                   CNT_BITS  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0]  CNT_LOAD  = CNT_BITS'(SETTLE_CYCLES);
  localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);
  localparam logic [CH_BITS-1:0]   CH_ZERO   = CH_BITS'(0);
  localparam logic [CH_BITS-1:0]   CH_ONE    = CH_BITS'(1);
  localparam logic [CH_BITS-1:0]   CH_LAST   = CH_BITS'(NUM_CHANNELS - 1);
  localparam logic [DATA_BITS-1:0] D_ZERO    = {DATA_BITS{1'b0}};
  localparam logic [DATA_BITS-1:0] D_ONE     = DATA_BITS'(1);
  localparam logic [DATA_BITS-1:0] D_MIN_NEG = {1'b1, {(DATA_BITS-1){1'b0}}};
  localparam logic [DATA_BITS-1:0] D_MAX_POS = {1'b0, {(DATA_BITS-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // The most negative sample has no positive twin, so it clips to the largest positive value.
  function automatic logic [DATA_BITS-1:0] abs_sat(input logic [DATA_BITS-1:0] x);
    logic [DATA_BITS-1:0] r;
    if (x == D_MIN_NEG) begin
      r = D_MAX_POS;
    end else if (x[DATA_BITS-1]) begin
      r = ~x + D_ONE;
    end else begin
      r = x;
    end
    return r;
  endfunction

  function automatic logic [DATA_BITS-1:0] decay_step(input logic [DATA_BITS-1:0] p);
    logic [DATA_BITS-1:0] d;
    d = p >> DECAY_SHIFT;
    if ((d == D_ZERO) && (p != D_ZERO)) begin
      d = D_ONE;
    end else begin
      d = d;
    end
    return p - d;
  endfunction

  state_t                  state_r;
  logic [CNT_BITS-1:0]     cnt_r;
  logic [CH_BITS-1:0]      ch_r;
  logic [DATA_BITS-1:0]    thr_r;
  logic [DATA_BITS-1:0]    peak_r [NUM_CHANNELS];
  logic [7:0]              select_r;
  logic [NUM_CHANNELS-1:0] active_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    overrun_r;

  logic [DATA_BITS-1:0]    sample_abs_s;
  logic [DATA_BITS-1:0]    cur_peak_s;
  logic [DATA_BITS-1:0]    new_peak_s;
  logic [DATA_BITS-1:0]    read_peak_s;

  // Next peak value for the channel currently being captured.
  always_comb begin
    sample_abs_s = abs_sat(bus.wavelet_value);
    cur_peak_s   = peak_r[ch_r];
    new_peak_s   = (sample_abs_s > cur_peak_s) ? sample_abs_s : decay_step(cur_peak_s);
  end

  // Firmware read port; indices past the last channel read as zero.
  always_comb begin
    read_peak_s = D_ZERO;
    if (int'(bus.read_channel) < NUM_CHANNELS) begin
      read_peak_s = peak_r[bus.read_channel];
    end else begin
      read_peak_s = D_ZERO;
    end
  end

  // Sweep sequencer with its registered status outputs and the per-channel peak/activity state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CNT_BITS{1'b0}};
      ch_r      <= CH_ZERO;
      thr_r     <= D_ZERO;
      select_r  <= 8'd0;
      active_r  <= {NUM_CHANNELS{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        peak_r[i] <= D_ZERO;
      end
    end else begin
      done_r <= 1'b0;
      if (bus.sweep_start && ((state_r == S_SETTLE) || (state_r == S_CAPTURE))) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        // DONE accepts a new start exactly like IDLE so sweeps can run back to back.
        S_IDLE, S_DONE: begin
          select_r <= 8'd0;
          if (bus.sweep_start) begin
            thr_r   <= bus.threshold;
            ch_r    <= CH_ZERO;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
            state_r <= S_SETTLE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (cnt_r == CNT_ONE) begin
            state_r <= S_CAPTURE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_CAPTURE: begin
          peak_r[ch_r]   <= new_peak_s;
          active_r[ch_r] <= (new_peak_s >= thr_r);
          if (ch_r == CH_LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            ch_r     <= ch_r + CH_ONE;
            select_r <= 8'(ch_r + CH_ONE);
            cnt_r    <= CNT_LOAD;
            state_r  <= S_SETTLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.select_output_channel = select_r;
  assign bus.peak                  = read_peak_s;
  assign bus.active                = active_r;
  assign bus.busy                  = busy_r;
  assign bus.sweep_done            = done_r;
  assign bus.overrun               = overrun_r;

endmodule

// File: tb/tb_wavelet_channel_scanner.sv
// Scoreboard bench for wavelet_channel_scanner: stimulus pushes expected sweep results computed
// from a plain arithmetic model; a negedge monitor checks timing, select stepping and results.
module tb_wavelet_channel_scanner;

  logic clk = 1'b0;
  logic rst;

  wavelet_channel_scanner_if bus ();

  wavelet_channel_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output multiplexer model: presents the value for whichever channel is selected.
  logic [7:0] mux_vals [8];
  always_comb begin
    bus.wavelet_value = 8'h00;
    if (bus.select_output_channel < 8'd8) begin
      bus.wavelet_value = mux_vals[bus.select_output_channel[2:0]];
    end
  end

  typedef struct {
    int         acc;
    logic [7:0] active;
    logic [7:0] peak;
  } exp_t;

  exp_t q[$];
  int   ref_peak [8];
  bit   exp_overrun;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int mag(input logic [7:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 127) s = 127;
    return s;
  endfunction

  // Reference: one whole sweep at a time, ch0..ch7, using the threshold latched at start.
  task automatic model_sweep(input int thr, input int rch);
    exp_t e;
    e.active = 8'h00;
    for (int c = 0; c < 8; c++) begin
      int a;
      int d;
      a = mag(mux_vals[c]);
      if (a > ref_peak[c]) begin
        ref_peak[c] = a;
      end else begin
        d = ref_peak[c] / 16;
        if (d == 0 && ref_peak[c] > 0) d = 1;
        ref_peak[c] = ref_peak[c] - d;
        if (ref_peak[c] < 0) ref_peak[c] = 0;
      end
      e.active[c] = (ref_peak[c] >= thr);
    end
    e.peak = 8'(ref_peak[rch]);
    e.acc  = cyc + 1;
    q.push_back(e);
  endtask

  exp_t mon_item;
  int   mon_k;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        mon_k = cyc - q[0].acc;
        if (mon_k >= 0 && mon_k <= 23) begin
          chk("busy_in_sweep", int'(bus.busy), 1);
          chk("select_step", int'(bus.select_output_channel), mon_k / 3);
        end
      end
      if (bus.sweep_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_item = q.pop_front();
          chk("done_latency", cyc - mon_item.acc, 24);
          chk("busy_at_done", int'(bus.busy), 0);
          chk("active_mask", int'(bus.active), int'(mon_item.active));
          chk("peak_read", int'(bus.peak), int'(mon_item.peak));
          chk("overrun_flag", int'(bus.overrun), int'(exp_overrun));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] thr, input logic [2:0] rch);
    bus.threshold    = thr;
    bus.read_channel = rch;
    bus.sweep_start  = 1'b1;
    model_sweep(int'(thr), int'(rch));
    tick();
    bus.sweep_start  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.sweep_done) seen = 1'b1;
      else tick();
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic pulse_mid(input int n, input logic [7:0] new_thr);
    repeat (n) tick();
    bus.sweep_start = 1'b1;
    bus.threshold   = new_thr;
    exp_overrun     = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
  endtask

  initial begin
    bit  b2b;
    int  r;
    bit  seen4;

    rst              = 1'b0;
    bus.sweep_start  = 1'b0;
    bus.threshold    = 8'h00;
    bus.read_channel = 3'd0;
    exp_overrun      = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mux_vals[c] = 8'h00;
      ref_peak[c] = 0;
    end

    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.sweep_done), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_active", int'(bus.active), 0);
    chk("rst_select", int'(bus.select_output_channel), 0);
    chk("rst_peak", int'(bus.peak), 0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    // Single active channel.
    mux_vals[3] = 8'h40;
    issue(8'h20, 3'd3);
    wait_done();
    tick();
    chk("peak3_first", int'(bus.peak), 64);
    chk("active_first", int'(bus.active), 8'h08);

    // Threshold raised mid-sweep only takes effect next sweep; peak decays.
    mux_vals[3] = 8'h00;
    issue(8'h20, 3'd3);
    repeat (5) tick();
    bus.threshold = 8'h50;
    wait_done();
    tick();
    chk("peak3_decay60", int'(bus.peak), 60);
    chk("active_old_thr", int'(bus.active), 8'h08);

    issue(8'h50, 3'd3);
    wait_done();
    tick();
    chk("peak3_decay57", int'(bus.peak), 57);
    chk("active_new_thr", int'(bus.active), 8'h00);

    issue(8'h50, 3'd3);
    wait_done();
    tick();
    chk("peak3_decay54", int'(bus.peak), 54);

    // Most negative sample saturates.
    mux_vals[0] = 8'h80;
    issue(8'h20, 3'd0);
    wait_done();
    tick();
    chk("peak0_saturate", int'(bus.peak), 127);
    chk("overrun_clear", int'(bus.overrun), 0);
    mux_vals[0] = 8'h00;

    // Start during a sweep is dropped; start in the DONE cycle runs back to back.
    mux_vals[5] = 8'h05;
    issue(8'h20, 3'd5);
    pulse_mid(7, 8'h20);
    wait_done();
    chk("overrun_set", int'(bus.overrun), 1);
    mux_vals[5] = 8'h00;
    issue(8'h10, 3'd5);
    wait_done();
    tick();
    chk("peak5_decay4", int'(bus.peak), 4);
    chk("overrun_sticky", int'(bus.overrun), 1);

    // Randomised sweeps.
    b2b = 1'b0;
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < 8; c++) begin
        r = $urandom_range(0, 5);
        case (r)
          0: mux_vals[c] = 8'h00;
          1: mux_vals[c] = 8'h80;
          2: mux_vals[c] = 8'h7f;
          3: mux_vals[c] = 8'h81;
          default: mux_vals[c] = 8'($urandom);
        endcase
      end
      issue(8'($urandom_range(0, 127)), b2b ? bus.read_channel : 3'($urandom_range(0, 7)));
      r = $urandom_range(0, 2);
      if (r == 0) begin
        pulse_mid($urandom_range(1, 20), 8'($urandom));
      end else if (r == 1) begin
        repeat ($urandom_range(1, 15)) tick();
        bus.threshold = 8'($urandom);
      end
      wait_done();
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) repeat ($urandom_range(1, 3)) tick();
    end
    repeat (2) tick();

    // Reset while channel 4 is settling.
    for (int c = 0; c < 8; c++) mux_vals[c] = 8'h33;
    issue(8'h10, 3'd4);
    seen4 = 1'b0;
    for (int i = 0; i < 30 && !seen4; i++) begin
      if (bus.select_output_channel == 8'd4) seen4 = 1'b1;
      else tick();
    end
    chk("reached_ch4", int'(seen4), 1);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) ref_peak[c] = 0;
    exp_overrun = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_select", int'(bus.select_output_channel), 0);
    chk("arst_active", int'(bus.active), 0);
    chk("arst_overrun", int'(bus.overrun), 0);
    chk("arst_done", int'(bus.sweep_done), 0);
    for (int c = 0; c < 8; c++) begin
      bus.read_channel = 3'(c);
      #1;
      chk("arst_peak", int'(bus.peak), 0);
    end
    tick();
    tick();
    rst = 1'b1;
    repeat (30) tick();

    // Fresh sweep after reset starts from zero peaks.
    for (int c = 0; c < 8; c++) mux_vals[c] = 8'(c * 20);
    issue(8'h30, 3'd6);
    wait_done();
    tick();
    chk("post_rst_peak6", int'(bus.peak), 120);

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
